// File: rtl/str_row_frame_assembler_if.sv
// Row-beat input and frame output handshake bundle for str_row_frame_assembler.
// master drives rows and accepts frames; slave is the assembler itself.
interface str_row_frame_assembler_if #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [COLS-1:0]        in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ROWS*COLS-1:0]   out_frame;
    logic                   err_len;
    logic [CNT_W-1:0]       frame_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_frame, err_len, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_frame, err_len, frame_cnt
    );
endinterface

// File: rtl/str_row_frame_assembler.sv
// Assembles ROWS row beats into a double-buffered ROWS*COLS frame (row r at
// bits [r*COLS +: COLS]); frames whose length disagrees with in_last are dropped.
module str_row_frame_assembler #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    str_row_frame_assembler_if.slave bus
);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned FRM_W = ROWS * COLS;

    typedef enum logic [1:0] {
        S_FILL      = 2'd0,
        S_FULL_WAIT = 2'd1,
        S_DROP      = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROW_W-1:0]   r_row_idx;
    logic [ROW_W-1:0]   w_row_nxt;
    logic [FRM_W-1:0]   r_fill;
    logic [FRM_W-1:0]   w_fill_nxt;
    logic [FRM_W-1:0]   w_fill_wr;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [FRM_W-1:0]   r_out_frame;
    logic               r_err_len;
    logic [CNT_W-1:0]   r_frame_cnt;

    logic               w_beat;
    logic               w_last_row;
    logic               w_slot_free;
    logic               w_load;
    logic [FRM_W-1:0]   w_load_frame;
    logic               w_err_nxt;

    assign w_beat      = bus.in_valid && r_in_ready;
    assign w_last_row  = (r_row_idx == ROW_W'(ROWS - 1));
    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Fill buffer with the current beat's row merged in at row_idx.
    always_comb begin
        w_fill_wr = r_fill;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (r_row_idx == ROW_W'(r)) begin
                w_fill_wr[r*COLS +: COLS] = bus.in_data;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row_idx;
        w_fill_nxt   = r_fill;
        w_load       = 1'b0;
        w_load_frame = r_fill;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_beat) begin
                    w_fill_nxt = w_fill_wr;
                    if (!w_last_row) begin
                        if (bus.in_last) begin
                            w_err_nxt  = 1'b1;
                            w_row_nxt  = '0;
                            w_fill_nxt = '0;
                        end else begin
                            w_row_nxt = r_row_idx + ROW_W'(1);
                        end
                    end else begin
                        w_row_nxt = '0;
                        if (!bus.in_last) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_DROP;
                        end else if (w_slot_free) begin
                            w_load       = 1'b1;
                            w_load_frame = w_fill_wr;
                        end else begin
                            w_state_nxt = S_FULL_WAIT;
                        end
                    end
                end
            end
            S_FULL_WAIT: begin
                if (r_out_valid && bus.out_ready) begin
                    w_load       = 1'b1;
                    w_load_frame = r_fill;
                    w_state_nxt  = S_FILL;
                end
            end
            S_DROP: begin
                if (w_beat && bus.in_last) begin
                    w_row_nxt   = '0;
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_row_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready follows the next state so it is low for the whole FULL_WAIT stay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_idx   <= '0;
            r_fill      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_frame <= '0;
            r_err_len   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_row_idx  <= w_row_nxt;
            r_fill     <= w_fill_nxt;
            r_in_ready <= (w_state_nxt != S_FULL_WAIT);
            r_err_len  <= w_err_nxt;
            if (w_load) begin
                r_out_frame <= w_load_frame;
                r_out_valid <= 1'b1;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_frame = r_out_frame;
    assign bus.err_len   = r_err_len;
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_str_row_frame_assembler.sv
// Scoreboard bench for str_row_frame_assembler: the driver queues expected frames,
// a negedge monitor pops and compares them on every output handshake.
module tb_str_row_frame_assembler;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [15:0] frame;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    str_row_frame_assembler_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) bus ();

    str_row_frame_assembler #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   seen_err = 0;
    int   exp_err  = 0;
    int   exp_cnt  = 0;
    bit   rand_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send_row(input logic [COLS-1:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f, input bit gap);
        exp_cnt++;
        exp_q.push_back('{frame: f, cnt: 16'(exp_cnt)});
        for (int r = 0; r < 4; r++) begin
            send_row(f[r*4 +: 4], r == 3);
            if (gap && r < 3) @(posedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.err_len) seen_err++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(bus.out_frame), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_frame", 32'(bus.out_frame), 32'(mon_e.frame));
                    chk("sb_cnt", 32'(bus.frame_cnt), 32'(mon_e.cnt));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_en) bus.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_frame"}, 32'(bus.out_frame), 32'd0);
        chk({tag, "_err_len"}, 32'(bus.err_len), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Basic frame, consumer always ready.
        send_frame(16'h8421, 1'b0);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_frame", 32'(bus.out_frame), 32'h8421);
        chk("t1_cnt", 32'(bus.frame_cnt), 32'd1);
        @(posedge clk); #1;
        chk("t1_valid_clear", 32'(bus.out_valid), 32'd0);

        // Back-to-back with consumer stalled.
        bus.out_ready = 1'b0;
        send_frame(16'hA5C3, 1'b0);
        send_frame(16'h3C5A, 1'b0);
        chk("t2_wait_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_hold_frame", 32'(bus.out_frame), 32'hA5C3);
        chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("t2_b_frame", 32'(bus.out_frame), 32'h3C5A);
        chk("t2_b_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_b_cnt", 32'(bus.frame_cnt), 32'd3);
        chk("t2_b_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t2_drained", 32'(bus.out_valid), 32'd0);
        chk("no_err_yet", 32'(seen_err), 32'd0);

        // Short frame.
        send_row(4'h3, 1'b0);
        send_row(4'h5, 1'b1);
        exp_err++;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_err_count", 32'(seen_err), 32'(exp_err));
        chk("t3_no_out", 32'(bus.out_valid), 32'd0);
        send_frame(16'h0F0F, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Long frame.
        for (int i = 0; i < 6; i++) send_row(4'(i + 1), i == 5);
        exp_err++;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_err_count", 32'(seen_err), 32'(exp_err));
        chk("t4_no_out", 32'(bus.out_valid), 32'd0);
        send_frame(16'hF731, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame.
        send_row(4'h9, 1'b0);
        send_row(4'h6, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while in FULL_WAIT.
        bus.out_ready = 1'b0;
        send_frame(16'h1234, 1'b0);
        send_frame(16'h5678, 1'b0);
        chk("t5_wait_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_wait");
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send_frame(16'hBEEF, 1'b0);
        chk("t5_frame", 32'(bus.out_frame), 32'hBEEF);
        chk("t5_cnt", 32'(bus.frame_cnt), 32'd1);
        @(posedge clk); #1;

        // Gapped input, random consumer backpressure.
        rand_en = 1'b1;
        for (int f = 0; f < 100; f++) send_frame(16'($urandom), 1'b1);
        rand_en = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_drain", 32'(exp_q.size()), 32'd0);
        chk("t6_cnt", 32'(bus.frame_cnt), 32'd101);
        @(posedge clk); #1;
        chk("t6_idle", 32'(bus.out_valid), 32'd0);
        chk("final_err_count", 32'(seen_err), 32'(exp_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/str_row_frame_assembler.md
Name: str_row_frame_assembler

Overview:
- Upstream feeder for the ROWS x COLS registered bit-array stage.
- Accepts one COLS-bit row per valid/ready beat and assembles ROWS rows into a ROWS*COLS-bit frame, flattened in the layout that stage expects.
- Double-buffered: a fill buffer collects rows while a separate output buffer holds the last complete frame until the consumer accepts it.
- Checks frame length against an in_last marker and discards malformed frames.

Parameters:
- ROWS, 4, rows per frame (>=2).
- COLS, 4, bits per row (>=1).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  row beat valid.
- in_ready  output  1  block can accept a row beat.
- in_data  input  COLS  row bits; in_data[c] is column c.
- in_last  input  1  marks the final row of a frame.
- out_valid  output  1  out_frame holds a complete frame.
- out_ready  input  1  consumer accepts out_frame.
- out_frame  output  ROWS*COLS  assembled frame; row r occupies bits [r*COLS +: COLS], so column c of row r is bit r*COLS+c.
- err_len  output  1  one-cycle pulse when a frame is discarded for bad length.
- frame_cnt  output  CNT_W  count of frames transferred to the output buffer; wraps.

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values:
  - in_ready=0 while rst_n is low; in_ready=1 from the first clk edge after release.
  - out_valid=0, out_frame=0, err_len=0, frame_cnt=0.
  - Internal state: row_idx=0, fill buffer=0, state FILL.
- Beat acceptance: a beat is accepted on a clk edge where in_valid && in_ready. Inputs are ignored otherwise.
- FSM states:
  - FILL: in_ready=1.
    - Each accepted beat writes in_data into fill row row_idx.
    - Case row_idx<ROWS-1 && !in_last: increment row_idx.
    - Case row_idx<ROWS-1 && in_last (short frame): pulse err_len next cycle, discard the fill, row_idx=0, stay in FILL.
    - Case row_idx==ROWS-1 && !in_last (long frame): pulse err_len, row_idx=0, go to DROP.
    - Case row_idx==ROWS-1 && in_last (complete frame): row_idx=0. Then:
      - If the output slot is free (!out_valid, or out_valid && out_ready in the same cycle): copy the fill buffer, including this beat's row, to out_frame; out_valid=1 next cycle; increment frame_cnt; stay in FILL.
      - Otherwise: go to FULL_WAIT.
  - FULL_WAIT: in_ready=0.
    - On out_valid && out_ready: copy the fill buffer to out_frame, keep out_valid=1, increment frame_cnt, go to FILL next cycle.
  - DROP: in_ready=1.
    - Accepted beats are discarded.
    - A beat with in_last returns the FSM to FILL with row_idx=0.
    - No further err_len pulse is produced in DROP.
- Output handshake:
  - out_valid stays high and out_frame stays stable until out_valid && out_ready.
  - A handshake with no new frame ready clears out_valid next cycle.
- Latency: the completing beat accepted at edge t gives out_valid=1 with the new frame after edge t (visible in cycle t+1). Throughput is one frame per ROWS cycles with no bubbles when out_ready=1.
- frame_cnt counts frames moved into the output buffer and wraps at 2^CNT_W.
- Rows in the fill buffer not written in the current frame are never exposed, because short frames are discarded.
- Reset mid-frame or mid-wait returns every output to its reset value immediately; the partial frame is lost.
- All outputs are registered. in_ready is a registered function of state.

Test Plan:
- ROWS=4, COLS=4, out_ready=1: send rows 0x1,0x2,0x4,0x8 with in_last on the 4th beat → out_valid one cycle after the 4th beat, out_frame=16'h8421, frame_cnt=1, err_len never asserted.
- Back-to-back frames A then B with out_ready held low: after A, send B's 4 rows → out_frame stays A, in_ready=0 in FULL_WAIT. Raise out_ready for one cycle → next cycle out_frame=B, out_valid=1, frame_cnt=2, in_ready=1.
- Short frame: 2 rows with in_last on the 2nd → one err_len pulse, no out_valid. A following good frame 0xF,0x0,0xF,0x0 → out_frame=16'h0F0F.
- Long frame: 6 rows with in_last on the 6th → err_len pulses once after the 4th row, beats 5–6 are dropped, no output. The next frame assembles correctly.
- Assert rst_n low after 2 rows of a frame, and again while in FULL_WAIT → outputs are 0 immediately. After release, a fresh 4-row frame gives a correct out_frame and frame_cnt=1.
- in_valid toggling every other cycle with random out_ready, 100 frames → every frame matches the scoreboard and frame_cnt=100.
